// File: rtl/tri_edge_sequencer.sv
// Walks the loader-built vertex table in RAM and streams three line-draw
// commands per triangle to the line rasteriser over a valid/ready handshake.
module tri_edge_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned MAX_TRIS    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_finish,
  output logic [ADDR_WIDTH-1:0]  ram_read_addr,
  input  logic [DATA_WIDTH-1:0]  ram_read_data,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [COORD_WIDTH-1:0] x0,
  output logic [COORD_WIDTH-1:0] y0,
  output logic [COORD_WIDTH-1:0] x1,
  output logic [COORD_WIDTH-1:0] y1,
  output logic [1:0]             tri_index,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW     = (MAX_TRIS < 2) ? 1 : $clog2(MAX_TRIS + 1);
  localparam logic [7:0]  MaxTris8 = 8'(MAX_TRIS);

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StRdVtx,
    StEmit,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic                   phase_q, phase_d;  // 0: address phase, 1: capture phase
  logic [1:0]             vtx_q, vtx_d;
  logic [1:0]             edge_q, edge_d;
  logic [CntW-1:0]        tri_q, tri_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [COORD_WIDTH-1:0] vx_q [3];
  logic [COORD_WIDTH-1:0] vx_d [3];
  logic [COORD_WIDTH-1:0] vy_q [3];
  logic [COORD_WIDTH-1:0] vy_d [3];

  logic [7:0]             cnt_raw;
  logic [7:0]             cnt_eff;
  logic [COORD_WIDTH-1:0] word_x;
  logic [COORD_WIDTH-1:0] word_y;
  logic [1:0]             src_sel;
  logic [1:0]             dst_sel;
  logic                   last_tri;

  always_comb begin
    cnt_raw  = ram_read_data[7:0];
    cnt_eff  = (cnt_raw > MaxTris8) ? MaxTris8 : cnt_raw;
    word_x   = ram_read_data[DATA_WIDTH-1 -: COORD_WIDTH];
    word_y   = ram_read_data[COORD_WIDTH-1:0];
    src_sel  = edge_q;
    dst_sel  = (edge_q == 2'd2) ? 2'd0 : edge_q + 2'd1;
    last_tri = !((tri_q + CntW'(1)) < cnt_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vtx_d   = vtx_q;
    edge_d  = edge_q;
    tri_d   = tri_q;
    cnt_d   = cnt_q;
    vx_d    = vx_q;
    vy_d    = vy_q;

    case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        if (load_finish) begin
          state_d = StRdCnt;
        end
      end

      StRdCnt: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (cnt_eff == 8'd0) begin
            state_d = StDone;
          end else begin
            cnt_d   = CntW'(cnt_eff);
            tri_d   = '0;
            vtx_d   = 2'd0;
            state_d = StRdVtx;
          end
        end
      end

      StRdVtx: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d     = 1'b0;
          vx_d[vtx_q] = word_x;
          vy_d[vtx_q] = word_y;
          if (vtx_q == 2'd2) begin
            edge_d  = 2'd0;
            state_d = StEmit;
          end else begin
            vtx_d = vtx_q + 2'd1;
          end
        end
      end

      StEmit: begin
        if (line_ready) begin
          if (edge_q == 2'd2) begin
            if (last_tri) begin
              state_d = StDone;
            end else begin
              tri_d   = tri_q + CntW'(1);
              vtx_d   = 2'd0;
              state_d = StRdVtx;
            end
          end else begin
            edge_d = edge_q + 2'd1;
          end
        end
      end

      StDone: begin
        state_d = StDone;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      vtx_q   <= 2'd0;
      edge_q  <= 2'd0;
      tri_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vtx_q   <= vtx_d;
      edge_q  <= edge_d;
      tri_q   <= tri_d;
      cnt_q   <= cnt_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
    end
  end

  // Outputs decode from registered state only, so line_valid never sees line_ready.
  always_comb begin
    ram_read_addr = '0;
    line_valid    = 1'b0;
    x0            = '0;
    y0            = '0;
    x1            = '0;
    y1            = '0;
    tri_index     = 2'd0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      StRdCnt: begin
        busy = 1'b1;
      end
      StRdVtx: begin
        busy          = 1'b1;
        ram_read_addr = ADDR_WIDTH'(1) + ADDR_WIDTH'(3) * ADDR_WIDTH'(tri_q)
                      + ADDR_WIDTH'(vtx_q);
      end
      StEmit: begin
        busy       = 1'b1;
        line_valid = 1'b1;
        x0         = vx_q[src_sel];
        y0         = vy_q[src_sel];
        x1         = vx_q[dst_sel];
        y1         = vy_q[dst_sel];
        tri_index  = 2'(tri_q);
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
